// File: rtl/filter_result_reader.sv
// Serialises the flattened filter_result bus into a tagged valid/ready element stream.
// Optional FILTER_READER_SNAPSHOT_EN captures the whole bus on the start edge.
module filter_result_reader #(
   parameter int unsigned FILTER_SIZE   = 15,
   parameter int unsigned OUTPUT_WIDTH  = 27,
   parameter int unsigned OUTPUT_HEIGHT = 27,
   parameter int unsigned ELEM_BIT      = 26
) (
   input  logic                                                       clock,
   input  logic                                                       reset,
   input  logic [FILTER_SIZE*ELEM_BIT*OUTPUT_WIDTH*OUTPUT_HEIGHT-1:0] filter_result,
   input  logic                                                       done,
   output logic [ELEM_BIT-1:0]                                        out_data,
   output logic                                                       out_valid,
   input  logic                                                       out_ready,
   output logic [$clog2(FILTER_SIZE)-1:0]                             out_filter,
   output logic [$clog2(OUTPUT_WIDTH)-1:0]                            out_x,
   output logic [$clog2(OUTPUT_HEIGHT)-1:0]                           out_y,
   output logic                                                       out_last,
   output logic                                                       frame_done,
   output logic                                                       busy,
   output logic                                                       overrun
);

   localparam int unsigned MAP_SZ = OUTPUT_WIDTH * OUTPUT_HEIGHT;
   localparam int unsigned BUS_W  = FILTER_SIZE * ELEM_BIT * MAP_SZ;
   localparam int unsigned KW     = $clog2(FILTER_SIZE);
   localparam int unsigned XW     = $clog2(OUTPUT_WIDTH);
   localparam int unsigned YW     = $clog2(OUTPUT_HEIGHT);
   localparam int unsigned AW     = $clog2(BUS_W);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t        r_state;
   logic          r_done_d;
   logic [KW-1:0] r_k;
   logic [YW-1:0] r_i;
   logic [XW-1:0] r_j;
   logic          r_valid;
   logic          r_busy;
   logic          r_frame_done;
   logic          r_overrun;

   logic             w_start;
   logic             w_hs;
   logic             w_last;
   logic             w_end;
   logic             w_load;
   int unsigned      w_lin;
   logic [AW-1:0]    w_base;
   logic [BUS_W-1:0] w_src;

   assign w_start = done & ~r_done_d;
   assign w_hs    = r_valid & out_ready;
   assign w_last  = r_valid & (r_k == KW'(FILTER_SIZE - 1)) & (r_i == YW'(OUTPUT_HEIGHT - 1))
                    & (r_j == XW'(OUTPUT_WIDTH - 1));
   assign w_end   = w_hs & w_last;
   // A start coincident with the final handshake opens the next frame instead of being flagged.
   assign w_load  = w_start & ((r_state == IDLE) | w_end);

`ifdef FILTER_READER_SNAPSHOT_EN
   logic [BUS_W-1:0] r_snap;

   always_ff @(posedge clock) begin
      if (w_load) r_snap <= filter_result;
   end

   assign w_src = r_snap;
`else
   assign w_src = filter_result;
`endif

   always_comb begin
      w_lin    = 32'(r_k) * MAP_SZ + 32'(r_i) * OUTPUT_WIDTH + 32'(r_j);
      w_base   = AW'(w_lin * ELEM_BIT);
      out_data = '0;
      if (r_valid) out_data = w_src[w_base +: ELEM_BIT];
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_done_d     <= 1'b0;
         r_k          <= '0;
         r_i          <= '0;
         r_j          <= '0;
         r_valid      <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_done_d     <= done;
         r_frame_done <= w_end;
         if (w_start && (r_state == STREAM) && !w_end) r_overrun <= 1'b1;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_state <= STREAM;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
                  r_k     <= '0;
                  r_i     <= '0;
                  r_j     <= '0;
               end
            end
            STREAM: begin
               if (w_hs) begin
                  if (w_last) begin
                     r_k <= '0;
                     r_i <= '0;
                     r_j <= '0;
                     if (!w_start) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                     end
                  end else if (r_j == XW'(OUTPUT_WIDTH - 1)) begin
                     r_j <= '0;
                     if (r_i == YW'(OUTPUT_HEIGHT - 1)) begin
                        r_i <= '0;
                        r_k <= r_k + 1'b1;
                     end else begin
                        r_i <= r_i + 1'b1;
                     end
                  end else begin
                     r_j <= r_j + 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign out_valid  = r_valid;
   assign busy       = r_busy;
   assign out_filter = r_k;
   assign out_x      = r_j;
   assign out_y      = r_i;
   assign out_last   = w_last;
   assign frame_done = r_frame_done;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_filter_result_reader.sv
// Self-checking bench for filter_result_reader: 2 filters of 3x3 maps, 8-bit elements valued 0..17.
module tb_filter_result_reader;

   localparam int unsigned FS = 2;
   localparam int unsigned OW = 3;
   localparam int unsigned OH = 3;
   localparam int unsigned EB = 8;
   localparam int unsigned NE = FS * OW * OH;

   typedef struct {
      logic [EB-1:0] data;
      logic [0:0]    k;
      logic [1:0]    x;
      logic [1:0]    y;
      logic          last;
   } vec_t;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic [NE*EB-1:0]  fr;
   logic              done = 1'b0;
   logic [EB-1:0]     out_data;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [0:0]        out_filter;
   logic [1:0]        out_x;
   logic [1:0]        out_y;
   logic              out_last;
   logic              frame_done;
   logic              busy;
   logic              overrun;

   vec_t        tbl [NE];
   vec_t        q [$];
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned n_beats  = 0;
   logic        prev_last = 1'b0;
   logic [3:0]  rdy_pat = 4'b1111;
   int unsigned rdy_ph = 0;

   filter_result_reader #(
      .FILTER_SIZE  (FS),
      .OUTPUT_WIDTH (OW),
      .OUTPUT_HEIGHT(OH),
      .ELEM_BIT     (EB)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .filter_result(fr),
      .done         (done),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_filter   (out_filter),
      .out_x        (out_x),
      .out_y        (out_y),
      .out_last     (out_last),
      .frame_done   (frame_done),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clock) begin
      #1;
      out_ready = rdy_pat[rdy_ph[1:0]];
      rdy_ph++;
   end

   // Scoreboard: the front entry must be presented on every valid cycle and is retired on handshake.
   always @(negedge clock) begin
      if (reset) begin
         chk("frame_done", frame_done, prev_last);
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("extra_beat", 1, 0);
            end else begin
               chk("out_data", out_data, q[0].data);
               chk("out_filter", out_filter, q[0].k);
               chk("out_x", out_x, q[0].x);
               chk("out_y", out_y, q[0].y);
               chk("out_last", out_last, q[0].last);
               if (out_ready) begin
                  void'(q.pop_front());
                  n_beats++;
               end
            end
         end else begin
            chk("idle_data", out_data, 0);
            chk("idle_last", out_last, 0);
         end
      end
      prev_last = reset && out_valid && out_ready && out_last;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_frame(input logic ff);
      vec_t v;
      for (int n = 0; n < NE; n++) begin
         v = tbl[n];
         if (ff) v.data = '1;
         q.push_back(v);
      end
   endtask

   task automatic start_frame(input int unsigned hold);
      push_frame(1'b0);
      done = 1'b1;
      for (int c = 0; c < hold; c++) tick();
      done = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      int c;
      for (c = 0; c < 400; c++) begin
         if (q.size() == 0 && !out_valid) break;
         tick();
      end
      chk(name, (q.size() == 0 && !out_valid) ? 1 : 0, 1);
      tick();
      tick();
   endtask

   task automatic wait_beats(input int unsigned target, input string name);
      int c;
      for (c = 0; c < 200; c++) begin
         if (n_beats >= target) break;
         tick();
      end
      chk(name, (n_beats >= target) ? 1 : 0, 1);
   endtask

   task automatic load_bus();
      logic [EB-1:0] val;
      for (int n = 0; n < NE; n++) begin
         val = EB'(n);
         fr[n*EB +: EB] = val;
      end
   endtask

   initial begin
      int unsigned base;
      int c;
      logic snap_mode;
      for (int n = 0; n < NE; n++) begin
         tbl[n].data = EB'(n);
         tbl[n].k    = 1'(n / (OW * OH));
         tbl[n].y    = 2'((n % (OW * OH)) / OW);
         tbl[n].x    = 2'(n % OW);
         tbl[n].last = (n == NE - 1);
      end
      load_bus();

      // Reset state
      tick(); tick(); tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_last", out_last, 0);
      chk("rst_data", out_data, 0);
      chk("rst_tags", {out_filter, out_x, out_y}, 0);
      reset = 1'b1;
      tick();

      // Ordering with done held high several cycles (single trigger only)
      start_frame(4);
      chk("busy_stream", busy, 1);
      wait_empty("order_complete");
      chk("order_overrun", overrun, 0);
      chk("order_busy_idle", busy, 0);

      // Backpressure 1,0,0,1
      rdy_pat = 4'b1001;
      start_frame(1);
      wait_empty("bp_complete");
      rdy_pat = 4'b1111;

      // Overrun at beat 5
      base = n_beats;
      start_frame(1);
      wait_beats(base + 5, "ovr_reach5");
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      chk("ovr_set", overrun, 1);
      wait_empty("ovr_complete");
      chk("ovr_sticky", overrun, 1);

      // Reset mid-frame at beat 7
      base = n_beats;
      start_frame(1);
      wait_beats(base + 7, "rst_reach7");
      reset = 1'b0;
      tick();
      chk("midrst_valid", out_valid, 0);
      chk("midrst_overrun", overrun, 0);
      chk("midrst_frame_done", frame_done, 0);
      q.delete();
      reset = 1'b1;
      tick();
      chk("midrst_no_fd", frame_done, 0);
      start_frame(1);
      wait_empty("restart_complete");

      // Back-to-back: done rises on the edge of the final handshake
      start_frame(1);
      for (c = 0; c < 200; c++) begin
         @(negedge clock);
         if (out_valid && out_last && out_ready) break;
      end
      chk("b2b_found_last", (out_valid && out_last) ? 1 : 0, 1);
      done = 1'b1;
      push_frame(1'b0);
      @(posedge clock);
      #1;
      done = 1'b0;
      chk("b2b_valid", out_valid, 1);
      chk("b2b_first", {out_data, out_filter, out_x, out_y}, 0);
      wait_empty("b2b_complete");
      chk("b2b_overrun", overrun, 0);

      // Bus changes after the start edge
`ifdef FILTER_READER_SNAPSHOT_EN
      snap_mode = 1'b1;
`else
      snap_mode = 1'b0;
`endif
      push_frame(~snap_mode);
      done = 1'b1;
      tick();
      done = 1'b0;
      fr = '1;
      wait_empty("snap_complete");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/filter_result_reader.md
# filter_result_reader

Consumer end of the convolution `filter` output bus. After the filter asserts `done`, this block walks the flattened `filter_result` vector. It emits one output element per accepted beat on a valid/ready stream, in filter-major, row-major order, and tags each beat with its filter index and (x, y) coordinates. Downstream pooling, activation or host readback logic then consumes feature maps serially instead of through the multi-hundred-kilobit parallel bus.

## Interface
- FILTER_SIZE, 15, number of filters (feature maps) in the bus
- OUTPUT_WIDTH, 27, feature map width
- OUTPUT_HEIGHT, 27, feature map height
- ELEM_BIT, 26, bits per result element (SUBKERNEL_OUT_BIT + CHANNEL_EXTENSION_BIT)
- clock  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-low (0 = reset, sampled on rising edge of clock)
- filter_result  input  FILTER_SIZE*ELEM_BIT*OUTPUT_WIDTH*OUTPUT_HEIGHT  flattened filter output
- done  input  1  filter completion level; rising edge starts a frame
- out_data  output  ELEM_BIT  current element, raw bits (no sign handling)
- out_valid  output  1  out_data and tags valid
- out_ready  input  1  downstream accepts the beat when out_valid & out_ready
- out_filter  output  $clog2(FILTER_SIZE)  filter index k of the beat
- out_x  output  $clog2(OUTPUT_WIDTH)  column j
- out_y  output  $clog2(OUTPUT_HEIGHT)  row i
- out_last  output  1  high with out_valid on the final element of the frame
- frame_done  output  1  one-cycle pulse after the final beat is accepted
- busy  output  1  high in STREAM
- overrun  output  1  sticky; a done rising edge arrived while in STREAM

## Operation
- Element (k, i, j) occupies bits [base+ELEM_BIT-1 : base], where base = ELEM_BIT*(k*OUTPUT_WIDTH*OUTPUT_HEIGHT + i*OUTPUT_WIDTH + j).
- The block registers done_d every cycle. start = done & ~done_d. done_d resets to 0.
- FSM states are IDLE and STREAM.
- IDLE: out_valid = 0 and busy = 0. On start, the counters k, i and j clear to 0 and the FSM moves to STREAM.
- STREAM: out_valid = 1, busy = 1, out_data = element(k, i, j), tags = (k, j, i).
- Each handshake advances the counters. j increments first. At OUTPUT_WIDTH-1, j wraps to 0 and i increments. At OUTPUT_HEIGHT-1, i wraps to 0 and k increments.
- out_last = out_valid & (k==FILTER_SIZE-1) & (i==OUTPUT_HEIGHT-1) & (j==OUTPUT_WIDTH-1).
- A handshake with out_last set moves the FSM to IDLE and pulses frame_done the following cycle.
- Without a handshake, all outputs hold. out_valid is never withdrawn before acceptance.
- A start while in STREAM is ignored and sets overrun. overrun clears only on reset.
- A start on the same edge as the last handshake is not lost: the FSM goes straight back to STREAM with the counters cleared, and overrun stays unchanged.
- done held high does not retrigger; a new frame needs done to fall and rise again.

## Timing
- Reset (reset=0 at an edge): state = IDLE, counters = 0, done_d = 0. out_valid, out_last, frame_done, busy and overrun are all 0. out_data = 0, and the tags = 0.
- Reset mid-frame aborts the frame immediately: no frame_done pulse, and the remaining elements are discarded.
- Latency: done first sampled high at edge N gives out_valid high in the cycle after edge N.
- Throughput: one element per cycle while out_ready = 1. A frame takes a minimum of FILTER_SIZE*OUTPUT_WIDTH*OUTPUT_HEIGHT cycles.
- frame_done is high for exactly the one cycle after the edge where the last handshake occurred.

## Configuration
- FILTER_READER_SNAPSHOT_EN defined:
  - The full filter_result bus is registered into an internal snapshot on the start edge, and out_data is sourced from the snapshot.
  - filter_result may change any time after the start edge.
  - The snapshot is not cleared by reset. out_data is still forced to 0 while out_valid = 0.
- Undefined:
  - out_data is a combinational mux of the live filter_result indexed by the counters, with no snapshot storage.
  - filter_result must stay stable from the start edge until frame_done.

## Test plan
Parameters for all scenarios: FILTER_SIZE=2, OUTPUT_WIDTH=3, OUTPUT_HEIGHT=3, ELEM_BIT=8; filter_result loaded with element value = linear index 0..17.
- Ordering: pulse done, out_ready=1 → 18 consecutive beats with out_data 0..17. Tags (k, x, y) run (0,0,0), (0,1,0), … up to (1,2,2). out_last is set only on value 17. frame_done pulses one cycle later.
- Backpressure: toggle out_ready 1,0,0,1,… → no beat is skipped or duplicated. out_data and tags stay stable while out_ready=0. The sequence is still 0..17.
- Overrun: second done rise at beat 5 → overrun=1 and stays 1. The frame completes normally with 18 beats.
- Reset mid-frame: reset=0 at beat 7 → the next cycle has out_valid=0 and overrun=0, with no frame_done. A new done rise restarts from value 0.
- Back-to-back: done rise coincident with the last handshake → out_valid stays 1 and the next beat is value 0, tags (0,0,0).
- Snapshot (macro defined): after the start edge, change filter_result to all 0xFF → the stream still emits 0..17. Without the macro, the same stimulus emits 0xFF from the change onward.
